axi_lsu_master: RTL

- AXI4-Lite master bridge that converts the CPU load/store unit's single-outstanding memory request into AXI read or write transactions.
- Sits directly upstream of the dmem slave port (slave 1) of the memory subsystem, through the interconnect.
- Exactly one transaction is in flight at a time. The CPU stalls on cpu_ready/cpu_resp_valid.

---
 rtl/axi_lsu_master.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/axi_lsu_master.sv
// AXI4-Lite master bridging the CPU load/store unit (one request in flight) onto AR/R or AW/W/B.
// Optional build macro AXI_LSU_TIMEOUT_EN adds a per-state handshake-wait timeout of TIMEOUT cycles.
module axi_lsu_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_wstrb,
    output logic                cpu_ready,
    output logic                cpu_resp_valid,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_err,
    output logic [ADDR_W-1:0]   ARADDR_M,
    output logic                ARVALID_M,
    input  logic                ARREADY_M,
    input  logic [DATA_W-1:0]   RDATA_M,
    input  logic [1:0]          RRESP_M,
    input  logic                RVALID_M,
    output logic                RREADY_M,
    output logic [ADDR_W-1:0]   AWADDR_M,
    output logic                AWVALID_M,
    input  logic                AWREADY_M,
    output logic [DATA_W-1:0]   WDATA_M,
    output logic [DATA_W/8-1:0] WSTRB_M,
    output logic                WVALID_M,
    input  logic                WREADY_M,
    input  logic [1:0]          BRESP_M,
    input  logic                BVALID_M,
    output logic                BREADY_M
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    logic                aw_done, w_done;
    logic                ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic                aw_fin, w_fin;
    logic                timeout_hit;

    assign cpu_ready = (state == IDLE);
    assign RREADY_M  = (state == RD_DATA);
    assign BREADY_M  = (state == WR_RESP);
    assign ARADDR_M  = addr_q;
    assign AWADDR_M  = addr_q;
    assign WDATA_M   = wdata_q;
    assign WSTRB_M   = wstrb_q;

    assign ar_hs  = ARVALID_M && ARREADY_M;
    assign r_hs   = RVALID_M && RREADY_M;
    assign aw_hs  = AWVALID_M && AWREADY_M;
    assign w_hs   = WVALID_M && WREADY_M;
    assign b_hs   = BVALID_M && BREADY_M;
    assign aw_fin = aw_done || aw_hs;
    assign w_fin  = w_done || w_hs;

`ifdef AXI_LSU_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT) + 1;

    logic [TO_W-1:0] to_cnt;
    logic            st_move;

    // Any transition this edge restarts the wait count for the next state.
    assign st_move = (state == IDLE) || ar_hs || r_hs || b_hs ||
                     ((state == WR_REQ) && aw_fin && w_fin);
    assign timeout_hit = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            to_cnt <= '0;
        else if (st_move || timeout_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    logic unused_ok;
    assign unused_ok = ^{RRESP_M[0], BRESP_M[0]};
`else
    assign timeout_hit = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{RRESP_M[0], BRESP_M[0], (TIMEOUT > 0)};
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state          <= IDLE;
            ARVALID_M      <= 1'b0;
            AWVALID_M      <= 1'b0;
            WVALID_M       <= 1'b0;
            cpu_resp_valid <= 1'b0;
            cpu_rdata      <= '0;
            cpu_err        <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wstrb_q        <= '0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
        end else begin
            cpu_resp_valid <= 1'b0;
            if (timeout_hit) begin
                state          <= IDLE;
                ARVALID_M      <= 1'b0;
                AWVALID_M      <= 1'b0;
                WVALID_M       <= 1'b0;
                cpu_resp_valid <= 1'b1;
                cpu_err        <= 1'b1;
                cpu_rdata      <= '0;
            end else begin
                case (state)
                    IDLE: if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_wdata;
                        wstrb_q <= cpu_wstrb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (cpu_we) begin
                            state     <= WR_REQ;
                            AWVALID_M <= 1'b1;
                            WVALID_M  <= 1'b1;
                        end else begin
                            state     <= RD_ADDR;
                            ARVALID_M <= 1'b1;
                        end
                    end
                    RD_ADDR: if (ar_hs) begin
                        ARVALID_M <= 1'b0;
                        state     <= RD_DATA;
                    end
                    RD_DATA: if (r_hs) begin
                        cpu_rdata      <= RDATA_M;
                        cpu_err        <= RRESP_M[1];
                        cpu_resp_valid <= 1'b1;
                        state          <= IDLE;
                    end
                    // AW and W retire independently; B is awaited only once both have.
                    WR_REQ: begin
                        if (aw_hs) begin
                            AWVALID_M <= 1'b0;
                            aw_done   <= 1'b1;
                        end
                        if (w_hs) begin
                            WVALID_M <= 1'b0;
                            w_done   <= 1'b1;
                        end
                        if (aw_fin && w_fin)
                            state <= WR_RESP;
                    end
                    WR_RESP: if (b_hs) begin
                        cpu_err        <= BRESP_M[1];
                        cpu_resp_valid <= 1'b1;
                        state          <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
